// File: rtl/icap_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : icap_seq_pkg
//  Description: Spartan-6 ICAP word constants, FSM state encoding and
//               sequence lengths shared by the multiboot sequencer.
//               Sequence length depends on macro ICAP_FALLBACK_EN.
//  Revision   : 1.0 - initial release
// ============================================================================
package icap_seq_pkg;

  // ICAP 16-bit configuration words
  localparam logic [15:0] c_dummy = 16'hFFFF;
  localparam logic [15:0] c_sync0 = 16'hAA99;
  localparam logic [15:0] c_sync1 = 16'h5566;
  localparam logic [15:0] c_gen1  = 16'h3261;  // write 1 word to GENERAL1
  localparam logic [15:0] c_gen2  = 16'h3281;  // write 1 word to GENERAL2
  localparam logic [15:0] c_gen3  = 16'h32A1;  // write 1 word to GENERAL3
  localparam logic [15:0] c_gen4  = 16'h32C1;  // write 1 word to GENERAL4
  localparam logic [15:0] c_cmd   = 16'h30A1;  // write 1 word to CMD
  localparam logic [15:0] c_iprog = 16'h000E;
  localparam logic [15:0] c_noop  = 16'h2000;

  // Number of words in the command list
  localparam logic [3:0] c_len_base     = 4'd10;
  localparam logic [3:0] c_len_fallback = 4'd14;
`ifdef ICAP_FALLBACK_EN
  localparam logic [3:0] c_len = c_len_fallback;
`else
  localparam logic [3:0] c_len = c_len_base;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/icap_seq_rom.sv
`default_nettype none
// ============================================================================
//  Module     : icap_seq_rom
//  Description: Combinational lookup of the IPROG command list. Maps a word
//               index to the 16-bit ICAP word, splicing in the latched
//               boot (and, with ICAP_FALLBACK_EN, golden) addresses.
//  Revision   : 1.0 - initial release
// ============================================================================
module icap_seq_rom
  import icap_seq_pkg::*;
#(
  parameter logic [7:0] FLASH_OPCODE = 8'h0B
) (
  input  logic [3:0]  i_index,
  input  logic [23:0] i_boot_addr,
`ifdef ICAP_FALLBACK_EN
  input  logic [23:0] i_golden_addr,
`endif
  output logic [15:0] o_word
);

  // Index to word decode; out-of-range indices read as NOOP
  always_comb begin
    o_word = c_noop;
    case (i_index)
      4'd0:  o_word = c_dummy;
      4'd1:  o_word = c_sync0;
      4'd2:  o_word = c_sync1;
      4'd3:  o_word = c_gen1;
      4'd4:  o_word = i_boot_addr[15:0];
      4'd5:  o_word = c_gen2;
      4'd6:  o_word = {FLASH_OPCODE, i_boot_addr[23:16]};
`ifdef ICAP_FALLBACK_EN
      4'd7:  o_word = c_gen3;
      4'd8:  o_word = i_golden_addr[15:0];
      4'd9:  o_word = c_gen4;
      4'd10: o_word = {FLASH_OPCODE, i_golden_addr[23:16]};
      4'd11: o_word = c_cmd;
      4'd12: o_word = c_iprog;
      4'd13: o_word = c_noop;
`else
      4'd7:  o_word = c_cmd;
      4'd8:  o_word = c_iprog;
      4'd9:  o_word = c_noop;
`endif
      default: o_word = c_noop;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/icap_multiboot_seq.sv
`default_nettype none
// ============================================================================
//  Module     : icap_multiboot_seq
//  Description: Wishbone master that writes the Spartan-6 IPROG multiboot
//               command list, one 16-bit ICAP word per write, with a fixed
//               idle gap after every ack and an ack timeout.
//               Macro ICAP_FALLBACK_EN adds the golden-image GENERAL3/4 words.
//  Revision   : 1.0 - initial release
// ============================================================================
module icap_multiboot_seq
  import icap_seq_pkg::*;
#(
  parameter logic [7:0]  FLASH_OPCODE = 8'h0B,
  parameter int unsigned WORD_GAP     = 16,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] boot_addr,
  input  logic [23:0] golden_addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] dat_o,
  input  logic        ack_i
);

  // The LOAD cycle is itself idle on the bus, so GAP lasts WORD_GAP-1 cycles
  // and the total idle time between ack and the next stb is WORD_GAP.
  localparam logic [15:0] c_gap_load = (WORD_GAP > 1) ? 16'(WORD_GAP - 1) : 16'd0;
  localparam logic [15:0] c_to_last  = (ACK_TIMEOUT > 0) ? 16'(ACK_TIMEOUT - 1) : 16'd0;

  state_t      r_state;
  state_t      w_state_nx;
  logic [3:0]  r_index;
  logic [15:0] r_dat;
  logic [15:0] r_gap_cnt;
  logic [15:0] r_to_cnt;
  logic        r_error;
  logic [23:0] r_boot;
  logic [15:0] w_word;
  logic        w_accept;
  logic        w_ack;
  logic        w_timeout;

`ifdef ICAP_FALLBACK_EN
  logic [23:0] r_golden;

  // Golden address snapshot, taken only when a start is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_golden <= 24'h0;
    end else if (w_accept) begin
      r_golden <= golden_addr;
    end
  end

  icap_seq_rom #(
    .FLASH_OPCODE (FLASH_OPCODE)
  ) u_rom (
    .i_index       (r_index),
    .i_boot_addr   (r_boot),
    .i_golden_addr (r_golden),
    .o_word        (w_word)
  );
`else
  logic w_unused_golden;
  assign w_unused_golden = ^golden_addr;

  icap_seq_rom #(
    .FLASH_OPCODE (FLASH_OPCODE)
  ) u_rom (
    .i_index     (r_index),
    .i_boot_addr (r_boot),
    .o_word      (w_word)
  );
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state and Wishbone/status outputs decoded from the current state
  always_comb begin
    w_state_nx = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    cyc_o      = 1'b0;
    stb_o      = 1'b0;
    we_o       = 1'b0;
    w_accept   = 1'b0;
    w_ack      = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept   = 1'b1;
          w_state_nx = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy       = 1'b1;
        w_state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        busy  = 1'b1;
        cyc_o = 1'b1;
        stb_o = 1'b1;
        we_o  = 1'b1;
        if (ack_i) begin
          // Leaving WRITE on the ack edge keeps stb low the following cycle
          w_ack      = 1'b1;
          w_state_nx = ST_GAP;
        end else if (r_to_cnt == c_to_last) begin
          w_timeout  = 1'b1;
          w_state_nx = ST_IDLE;
        end
      end
      ST_GAP: begin
        busy = 1'b1;
        if (r_gap_cnt <= 16'd1) begin
          w_state_nx = (r_index == c_len) ? ST_FINISH : ST_LOAD;
        end
      end
      ST_FINISH: begin
        done       = 1'b1;
        w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Datapath: address snapshot, word index, data register, gap/timeout counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_boot    <= 24'h0;
      r_index   <= 4'd0;
      r_dat     <= 16'h0;
      r_gap_cnt <= 16'h0;
      r_to_cnt  <= 16'h0;
      r_error   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_boot  <= boot_addr;
        r_index <= 4'd0;
        r_error <= 1'b0;
      end
      if (r_state == ST_LOAD) begin
        r_dat    <= w_word;
        r_to_cnt <= 16'h0;
      end
      if ((r_state == ST_WRITE) && !ack_i) begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end
      if (w_ack) begin
        r_index   <= r_index + 4'd1;
        r_gap_cnt <= c_gap_load;
      end
      if ((r_state == ST_GAP) && (r_gap_cnt != 16'h0)) begin
        r_gap_cnt <= r_gap_cnt - 16'd1;
      end
      if (w_timeout) begin
        r_error <= 1'b1;
      end
    end
  end

  assign dat_o = {16'h0, r_dat};
  assign error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_icap_multiboot_seq.sv
`default_nettype none
// ============================================================================
//  Module     : tb_icap_multiboot_seq
//  Description: Directed self-checking bench for icap_multiboot_seq with a
//               Wishbone responder that acks one cycle after stb.
//               Honours ICAP_FALLBACK_EN for the expected word list.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_icap_multiboot_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [23:0] boot_addr;
  logic [23:0] golden_addr;
  logic        busy;
  logic        done;
  logic        error;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [31:0] dat_o;
  logic        ack_i;
  logic        ack_en;

`ifdef ICAP_FALLBACK_EN
  localparam int c_len = 14;
  logic [15:0] exp_seq [0:13] = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, 16'h0000,
                                  16'h3281, 16'h0B0A, 16'h32A1, 16'h0000, 16'h32C1,
                                  16'h0B00, 16'h30A1, 16'h000E, 16'h2000};
`else
  localparam int c_len = 10;
  logic [15:0] exp_seq [0:9]  = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, 16'h0000,
                                  16'h3281, 16'h0B0A, 16'h30A1, 16'h000E, 16'h2000};
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor records (written only by the monitor process)
  logic [15:0] cap [0:255];
  int          rise_cyc [0:255];
  int          n_cap       = 0;
  int          n_rise      = 0;
  int          n_viol      = 0;
  int          done_total  = 0;
  int          cyc_cnt     = 0;
  logic        prev_ack    = 1'b0;
  logic        prev_stb    = 1'b0;

  icap_multiboot_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .boot_addr   (boot_addr),
    .golden_addr (golden_addr),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .cyc_o       (cyc_o),
    .stb_o       (stb_o),
    .we_o        (we_o),
    .dat_o       (dat_o),
    .ack_i       (ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Slave model: ack one cycle after stb, only on stb & ~ack
  always @(posedge clk) ack_i <= stb_o & ~ack_i & ack_en;

  // Bus monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (stb_o && ack_i) begin
      cap[n_cap[7:0]] = dat_o[15:0];
      n_cap = n_cap + 1;
    end
    if (prev_ack && stb_o) n_viol = n_viol + 1;
    if (stb_o && !prev_stb) begin
      rise_cyc[n_rise[7:0]] = cyc_cnt;
      n_rise = n_rise + 1;
    end
    if (done) done_total = done_total + 1;
    prev_ack = ack_i;
    prev_stb = stb_o;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next falling edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, {31'h0, seen}, 32'h1);
    check({tag, "_busy_at_done"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic check_seq(input string tag, input int base);
    check({tag, "_word_count"}, n_cap - base, c_len);
    for (int i = 0; i < c_len; i++)
      check($sformatf("%s_w%0d", tag, i), {16'h0, cap[(base + i) % 256]}, {16'h0, exp_seq[i]});
  endtask

  initial begin
    int base;
    int rbase;
    int dbase;
    int cnt;
    reset       = 1'b1;
    start       = 1'b0;
    ack_en      = 1'b1;
    boot_addr   = 24'h0A0000;
    golden_addr = 24'h000000;
    repeat (3) tick();

    // Reset state
    check("rst_busy",  {31'h0, busy},  32'h0);
    check("rst_done",  {31'h0, done},  32'h0);
    check("rst_error", {31'h0, error}, 32'h0);
    check("rst_cyc",   {31'h0, cyc_o}, 32'h0);
    check("rst_stb",   {31'h0, stb_o}, 32'h0);
    check("rst_we",    {31'h0, we_o},  32'h0);
    check("rst_dat",   dat_o,          32'h0);
    reset = 1'b0;
    repeat (2) tick();

    // Test 1/2: full sequence, word order and stb spacing
    base  = n_cap;
    rbase = n_rise;
    dbase = done_total;
    pulse_start();
    check("t1_busy_after_start", {31'h0, busy}, 32'h1);
    wait_done("t1");
    repeat (3) tick();
    check_seq("t1", base);
    check("t1_done_count", done_total - dbase, 1);
    check("t1_busy_end", {31'h0, busy}, 32'h0);
    check("t2_rise_count", n_rise - rbase, c_len);
    for (int i = 1; i < c_len; i++)
      check($sformatf("t2_spacing_%0d", i),
            rise_cyc[(rbase + i) % 256] - rise_cyc[(rbase + i - 1) % 256], 18);

    // Test 3: no ack -> timeout, error sticky, no done
    ack_en = 1'b0;
    dbase  = done_total;
    pulse_start();
    for (int i = 0; i < 10 && !stb_o; i++) tick();
    cnt = 0;
    while (stb_o && cnt < 400) begin
      cnt++;
      tick();
    end
    check("t3_stb_high_cycles", cnt, 255);
    check("t3_error", {31'h0, error}, 32'h1);
    check("t3_stb_low", {31'h0, stb_o}, 32'h0);
    check("t3_busy_low", {31'h0, busy}, 32'h0);
    repeat (5) tick();
    check("t3_error_sticky", {31'h0, error}, 32'h1);
    check("t3_no_done", done_total - dbase, 0);
    ack_en = 1'b1;
    repeat (2) tick();
    base = n_cap;
    pulse_start();
    check("t3_error_cleared", {31'h0, error}, 32'h0);
    wait_done("t3r");
    tick();
    check_seq("t3r", base);

    // Test 4: start while busy and boot_addr change mid-sequence
    base = n_cap;
    pulse_start();
    for (int i = 0; i < 200 && n_cap < base + 3; i++) tick();
    boot_addr = 24'h123456;
    pulse_start();
    repeat (20) tick();
    pulse_start();
    wait_done("t4");
    tick();
    check_seq("t4", base);
    check("t4_error", {31'h0, error}, 32'h0);
    boot_addr = 24'h0A0000;
    repeat (2) tick();

    // Test 5: reset (together with start) during word 5, then replay
    base = n_cap;
    pulse_start();
    for (int i = 0; i < 400 && !(n_cap == base + 5 && stb_o); i++) tick();
    check("t5_reached_word5", {31'h0, stb_o}, 32'h1);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("t5_cyc",  {31'h0, cyc_o}, 32'h0);
    check("t5_stb",  {31'h0, stb_o}, 32'h0);
    check("t5_busy", {31'h0, busy},  32'h0);
    check("t5_dat",  dat_o,          32'h0);
    tick();
    check("t5_start_lost_to_reset", {31'h0, busy}, 32'h0);
    repeat (2) tick();
    base = n_cap;
    pulse_start();
    wait_done("t5r");
    tick();
    check_seq("t5r", base);

    check("stb_after_ack", n_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
